// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the MIPS datapath blocks.
// Contents: hilo_state_t, the HI/LO unit FSM state (idle or dividing).
package mips_pkg;
    typedef enum logic {HILO_IDLE, HILO_DIV} hilo_state_t;
endpackage

// File: rtl/hilo_div_unit_div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports: rem/quot/divisor in (N each); rem_nx/quot_nx out (N each).
// The dividend is shifted out of quot's MSB into rem while quotient bits
// are shifted into quot's LSB.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] quot,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_nx,
    output logic [N-1:0] quot_nx
);
    logic [N:0] shifted;
    logic [N:0] diff;
    always_comb begin
        shifted = {rem, quot[N-1]};
        diff    = shifted - {1'b0, divisor};
        // A borrow out of the trial subtraction means restore the shifted value
        rem_nx  = diff[N] ? shifted[N-1:0] : diff[N-1:0];
        quot_nx = {quot[N-2:0], ~diff[N]};
    end
endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: MIPS HI/LO registers with product capture, MTHI/MTLO and an N-cycle restoring divider.
// Ports: clk, reset (sync, active-high); mult_we/alu_hi/alu_lo capture a product;
//        div_start/dividend/divisor start a divide (div_signed only with HILO_SIGNED_DIV_EN);
//        mthi/mtlo/wdata write HI/LO; hi/lo registers out; busy, done pulse, sticky div_zero.
// Config macro: HILO_SIGNED_DIV_EN adds div_signed and signed divide support.
module hilo_div_unit
    import mips_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mult_we,
    input  logic [N-1:0] alu_hi,
    input  logic [N-1:0] alu_lo,
    input  logic         div_start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
`ifdef HILO_SIGNED_DIV_EN
    input  logic         div_signed,
`endif
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);
    localparam int CW = $clog2(N);
    hilo_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] hi_q, hi_d, lo_q, lo_d, rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic done_q, done_d, dz_q, dz_d, negq_q, negq_d, negr_q, negr_d;
    logic [N-1:0] step_rem, step_quot, a_mag, b_mag;
    logic a_neg, b_neg;
`ifdef HILO_SIGNED_DIV_EN
    assign a_neg = div_signed & dividend[N-1];
    assign b_neg = div_signed & divisor[N-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    div_step #(.N(N)) u_step (
        .rem     (rem_q),
        .quot    (quot_q),
        .divisor (dvsr_q),
        .rem_nx  (step_rem),
        .quot_nx (step_quot)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        dz_d    = dz_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        done_d  = 1'b0;
        if (state_q == HILO_IDLE) begin
            if (div_start) begin
                state_d = HILO_DIV;
                cnt_d   = '0;
                rem_d   = '0;
                quot_d  = a_mag;
                dvsr_d  = b_mag;
                dz_d    = (divisor == '0);
                // A zero divisor keeps the raw all-ones quotient; remainder re-sign restores the raw dividend
                negq_d  = (a_neg ^ b_neg) & (divisor != '0);
                negr_d  = a_neg;
            end else if (mult_we) begin
                hi_d = alu_hi;
                lo_d = alu_lo;
            end else begin
                hi_d = mthi ? wdata : hi_q;
                lo_d = mtlo ? wdata : lo_q;
            end
        end else begin
            rem_d  = step_rem;
            quot_d = step_quot;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
                state_d = HILO_IDLE;
                cnt_d   = '0;
                hi_d    = negr_q ? -step_rem : step_rem;
                lo_d    = negq_q ? -step_quot : step_quot;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HILO_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == HILO_DIV);
    assign done     = done_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: self-checking bench for hilo_div_unit (N=32) against an arithmetic reference model.
module tb_hilo_div_unit;
    localparam int N = 32;
    logic clk = 1'b0;
    logic reset, mult_we, div_start, mthi, mtlo, div_signed;
    logic [N-1:0] alu_hi, alu_lo, dividend, divisor, wdata, hi, lo;
    logic busy, done, div_zero;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hilo_div_unit #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mult_we   (mult_we),
        .alu_hi    (alu_hi),
        .alu_lo    (alu_lo),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef HILO_SIGNED_DIV_EN
        .div_signed(div_signed),
`endif
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: MIPS divide semantics from plain arithmetic
    task automatic model_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                             output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Starts a divide, scrambles operands after acceptance, counts busy cycles (bounded)
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, output int bcyc);
        dividend = a;
        divisor = b;
        div_signed = s;
        div_start = 1'b1;
        tick;
        div_start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        div_signed = ~s;
        bcyc = 0;
        while (busy === 1'b1 && bcyc < 40) begin
            bcyc++;
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        total++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || div_zero !== 0) begin
            bad++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b expected all zero", hi, lo, busy, done, div_zero);
        end
    endtask

    task automatic test_mult_mt;
        logic [31:0] eh, el, w;
        mult_we = 1'b1; alu_hi = 0; alu_lo = 512;
        tick;
        mult_we = 1'b0;
        total++;
        if (hi !== 0 || lo !== 512) begin
            bad++;
            $display("FAIL mult_capture: hi=%h lo=%h expected 0/200", hi, lo);
        end
        mthi = 1'b1; wdata = 7;
        tick;
        mthi = 1'b0;
        total++;
        if (hi !== 7 || lo !== 512) begin
            bad++;
            $display("FAIL mthi: hi=%h lo=%h expected 7/200", hi, lo);
        end
        for (int i = 0; i < 4; i++) begin
            eh = $urandom; el = $urandom; w = $urandom;
            mult_we = 1'b1; alu_hi = eh; alu_lo = el; mthi = 1'b1; mtlo = 1'b1; wdata = w;
            tick;
            mult_we = 1'b0;
            total++;
            if (hi !== eh || lo !== el) begin
                bad++;
                $display("FAIL mult_over_mt: hi=%h lo=%h expected %h/%h", hi, lo, eh, el);
            end
            tick;
            mthi = 1'b0; mtlo = 1'b0;
            total++;
            if (hi !== w || lo !== w) begin
                bad++;
                $display("FAIL mthi_mtlo_both: hi=%h lo=%h expected %h/%h", hi, lo, w, w);
            end
        end
    endtask

    task automatic test_divide;
        logic [31:0] a, b, q, r;
        int bc;
        for (int i = 0; i < 10; i++) begin
            a = (i == 0) ? 32'd100 : $urandom;
            b = (i == 0) ? 32'd7 : (($urandom >> $urandom_range(0, 31)) | 32'd1);
            model_div(a, b, 1'b0, q, r);
            run_div(a, b, 1'b0, bc);
            total++;
            if (bc !== 32 || done !== 1'b1 || lo !== q || hi !== r || div_zero !== 1'b0) begin
                bad++;
                $display("FAIL divide %h/%h: busy_cycles=%0d done=%b lo=%h hi=%h dz=%b expected 32 1 %h %h 0",
                         a, b, bc, done, lo, hi, div_zero, q, r);
            end
            tick;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL done_pulse: done=%b expected 0", done);
            end
        end
    endtask

    task automatic test_div_zero;
        int bc;
        run_div(32'd5, 32'd0, 1'b0, bc);
        total++;
        if (bc !== 32 || lo !== 32'hFFFF_FFFF || hi !== 32'd5 || div_zero !== 1'b1) begin
            bad++;
            $display("FAIL div_zero: cycles=%0d lo=%h hi=%h dz=%b expected 32 ffffffff 5 1", bc, lo, hi, div_zero);
        end
        tick;
        total++;
        if (div_zero !== 1'b1) begin
            bad++;
            $display("FAIL div_zero_sticky: dz=%b expected 1", div_zero);
        end
        run_div(32'd9, 32'd3, 1'b0, bc);
        total++;
        if (lo !== 32'd3 || hi !== 32'd0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL div_zero_clear: lo=%h hi=%h dz=%b expected 3 0 0", lo, hi, div_zero);
        end
    endtask

    task automatic test_ignore_busy;
        int bc;
        mult_we = 1'b1; alu_hi = 32'hAAAA_0001; alu_lo = 32'h5555_0002;
        tick;
        mult_we = 1'b0;
        dividend = 100; divisor = 7; div_start = 1'b1;
        tick;
        div_start = 1'b0;
        tick;
        tick;
        div_start = 1'b1; dividend = 1; divisor = 1;
        mult_we = 1'b1; alu_hi = 32'h1234; alu_lo = 32'h5678;
        mtlo = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
        tick;
        div_start = 1'b0; mult_we = 1'b0; mtlo = 1'b0; mthi = 1'b0;
        total++;
        if (busy !== 1'b1 || hi !== 32'hAAAA_0001 || lo !== 32'h5555_0002) begin
            bad++;
            $display("FAIL busy_hold: busy=%b hi=%h lo=%h expected 1 aaaa0001 55550002", busy, hi, lo);
        end
        bc = 3;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            tick;
        end
        total++;
        if (bc !== 32 || done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
            bad++;
            $display("FAIL busy_ignore: cycles=%0d done=%b lo=%h hi=%h expected 32 1 e 2", bc, done, lo, hi);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        dividend = 100; divisor = 7; div_start = 1'b1;
        tick;
        div_start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            bad++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b expected 0 0 0 0", hi, lo, busy, done);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: busy/done cycles=%0d expected 0", seen);
        end
    endtask

`ifdef HILO_SIGNED_DIV_EN
    task automatic test_signed;
        logic [31:0] a, b, q, r;
        int bc;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 32'hFFFF_FFF9 : (i == 1) ? 32'h8000_0000 : (i == 2) ? 32'hFFFF_FFF9 : $urandom;
            b = (i == 0) ? 32'd2 : (i == 1) ? 32'hFFFF_FFFF : (i == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            model_div(a, b, 1'b1, q, r);
            run_div(a, b, 1'b1, bc);
            total++;
            if (bc !== 32 || lo !== q || hi !== r || div_zero !== (b == 0)) begin
                bad++;
                $display("FAIL signed %h/%h: cycles=%0d lo=%h hi=%h dz=%b expected 32 %h %h %b",
                         a, b, bc, lo, hi, div_zero, q, r, b == 0);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0; mult_we = 1'b0; div_start = 1'b0; mthi = 1'b0; mtlo = 1'b0; div_signed = 1'b0;
        alu_hi = 0; alu_lo = 0; dividend = 0; divisor = 0; wdata = 0;
        #1;
        test_reset;
        test_mult_mt;
        test_divide;
        test_div_zero;
        test_ignore_busy;
        test_reset_mid;
`ifdef HILO_SIGNED_DIV_EN
        test_signed;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
